mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Responder (memory side) of the core's mem_read/mem_write/mem_resp data-port handshake.
//  Word-organised storage; byte lanes are written under rv32i_mem_wmask; latency is programmable.
//  Sits opposite the datapath's load/store unit, in place of the cache/arbiter, for bring-up and verification.
// PARAMETERS
//  ADDR_WIDTH  12  word-index bits; storage = 2**ADDR_WIDTH 32-bit words (16 KiB)
//  LATENCY     3   cycles from request capture to mem_resp; legal range 1..255
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   reset, asynchronous, active-high
//  mem_read         in   1   read request; held high until mem_resp
//  mem_write        in   1   write request; held high until mem_resp
//  mem_address      in   32  byte address (rv32i_word)
//  mem_wdata        in   32  write data, lane-aligned (rv32i_word)
//  mem_byte_enable  in   4   write lane mask (rv32i_mem_wmask); bit i -> wdata[8i+7:8i]
//  mem_rdata        out  32  read data; valid in the mem_resp cycle
//  mem_resp         out  1   one-cycle completion pulse
//  mem_err          out  1   error flag, only with MEM_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: async assert -> FSM=IDLE, mem_resp=0, mem_rdata=0, cnt=0, mem_err=0.
//   Storage is never reset.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: on a clk edge with (mem_read|mem_write)=1, capture addr/wdata/mask/op; cnt=LATENCY-1.
//    Next state: WAIT if LATENCY>1, else RESP.
//   WAIT: cnt decrements each cycle; at cnt==1 -> RESP.
//   RESP: mem_resp=1 for exactly this cycle; then IDLE.
//  Latency: request captured at edge N -> mem_resp high in the cycle after edge N+LATENCY-1,
//   i.e. LATENCY cycles after capture. LATENCY=1 gives resp the cycle after capture.
//  Captured values are used; input changes after capture are ignored (protocol violation, no error).
//  Addressing: word index = mem_address[ADDR_WIDTH+1:2].
//   Bits [1:0] are ignored; bits above ADDR_WIDTH+1 are ignored (aliasing/wrap).
//  Write: committed on the edge ending the RESP cycle; only lanes whose mask bit is 1 change.
//   mask=4'b0000 -> no storage change, mem_resp still pulses.
//  Read: mem_rdata = full 32-bit word at index, registered at the edge entering RESP.
//   Holds its value until the next read response. Lane extraction/sign-extension is the core's job.
//  read & write both high at capture: a write is performed. mem_rdata returns the pre-write word.
//  Back-to-back: a request still high in the cycle after RESP is a new request.
//   It is captured at that IDLE edge; minimum one idle cycle between responses.
//  Reset mid-operation: pending op discarded, no write commits, no mem_resp.
//   mem_resp must not glitch high after reset release.
// CONFIGURATION
//  MEM_ERR_EN defined:
//   - port mem_err present; driven only in the RESP cycle, 0 otherwise.
//   - mem_err=1 when captured mem_address[1:0]!=0, or mem_address[31:ADDR_WIDTH+2]!=0.
//   - erroring write: storage unchanged. erroring read: mem_rdata=32'h0. mem_resp still pulses.
//  MEM_ERR_EN undefined: mem_err port absent; no checks; behaviour as BEHAVIOUR above.
// TESTING
//  1 rst=1 mid-WAIT of a write 0x10<-0xDEADBEEF, release, read 0x10
//     -> no resp during rst, read returns prior contents.
//  2 write 0x40<-0x11223344 mask 4'b1111, then read 0x40
//     -> resp exactly LATENCY(3) cycles after each capture, rdata=0x11223344.
//  3 write 0x40<-0xAABBCCDD mask 4'b0101, read 0x40
//     -> rdata=0x11BB33DD; mask 4'b0000 write -> unchanged, resp still pulses.
//  4 LATENCY=1 build, reads 0x0,0x4,0x8 held back-to-back
//     -> resp every 2nd cycle, correct data each, never 2 consecutive resp cycles.
//  5 ADDR_WIDTH=12: write 0x4000<-0xCAFEF00D, read 0x0000
//     -> rdata=0xCAFEF00D (alias).
//     With MEM_ERR_EN: mem_err=1, no write, and read 0x0000 returns the old value.
//  6 read&write both high at 0x20 (old 0x0, wdata 0x5A5A5A5A)
//     -> rdata=0x00000000; a following read returns 0x5A5A5A5A.
//     With MEM_ERR_EN: addr 0x22 -> mem_err=1.

Source files
------------

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//   Data-port handshake between the core's load/store unit (master) and a
//   memory responder (slave). The optional mem_err signal exists only when
//   the MEM_ERR_EN macro is defined.
// ----------------------------------------------------------------------------
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
`ifdef MEM_ERR_EN
    logic        mem_err;
`endif

    // Core / load-store unit side
    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        output mem_byte_enable,
        input  mem_rdata,
        input  mem_resp
`ifdef MEM_ERR_EN
        , input mem_err
`endif
    );

    // Memory responder side
    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        input  mem_byte_enable,
        output mem_rdata,
        output mem_resp
`ifdef MEM_ERR_EN
        , output mem_err
`endif
    );
endinterface : mem_responder_if

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the core's mem_read/mem_write/mem_resp port.
//   Word-organised storage of 2**ADDR_WIDTH 32-bit words, byte-lane writes,
//   fixed programmable latency (LATENCY cycles from capture to mem_resp,
//   legal range 1..255).
//
//   Optional feature macro: MEM_ERR_EN
//     When defined, misaligned addresses (bits [1:0] != 0) or addresses
//     beyond the storage window (bits [31:ADDR_WIDTH+2] != 0) complete with
//     mem_err=1 in the response cycle; an erroring write leaves storage
//     unchanged and an erroring read returns zero. When undefined, those
//     address bits are simply ignored (aliasing / wrap).
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 3
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [7:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [3:0]              r_be;
    logic                    r_rd;
    logic                    r_wr;
    logic [31:0]             r_rdata;
    logic                    r_resp;
    logic [31:0]             r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                    w_req;
    logic [ADDR_WIDTH-1:0]   w_in_idx;
    logic [ADDR_WIDTH-1:0]   w_rd_idx;
    logic [31:0]             w_rd_word;
    logic                    w_enter_resp;
    logic                    w_enter_rd;
    logic                    w_err_now;
    logic                    w_commit;

    assign w_req    = bus.mem_read | bus.mem_write;
    assign w_in_idx = bus.mem_address[ADDR_WIDTH+1:2];

    // With LATENCY=1 the RESP state is entered on the capture edge itself,
    // so the read must use the live address instead of the captured one.
    assign w_rd_idx   = (r_state == S_IDLE) ? w_in_idx : r_idx;
    assign w_rd_word  = r_mem[w_rd_idx];
    assign w_enter_rd = (r_state == S_IDLE) ? bus.mem_read : r_rd;

    assign w_enter_resp = ((r_state == S_IDLE) && w_req && (LATENCY == 1)) ||
                          ((r_state == S_WAIT) && (r_cnt == 8'd1));

`ifdef MEM_ERR_EN
    logic w_in_err;
    logic r_err_cap;
    logic r_err;

    assign w_in_err  = (|bus.mem_address[1:0]) | (|bus.mem_address[31:ADDR_WIDTH+2]);
    assign w_err_now = (r_state == S_IDLE) ? w_in_err : r_err_cap;
    assign w_commit  = (r_state == S_RESP) && r_wr && !r_err_cap;

    // Latch the address-error verdict with the request; present it only in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cap <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_req) begin
                r_err_cap <= w_in_err;
            end
            r_err <= w_enter_resp ? w_err_now : 1'b0;
        end
    end

    assign bus.mem_err = r_err;
`else
    // Address bits outside the word index are deliberately ignored.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{bus.mem_address[1:0], bus.mem_address[31:ADDR_WIDTH+2]};
    assign w_err_now = 1'b0;
    assign w_commit  = (r_state == S_RESP) && r_wr;
`endif

    // ------------------------------------------------------------------
    // Handshake FSM: capture request, count latency, pulse mem_resp
    // ------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 32'h0;
            r_resp  <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx   <= w_in_idx;
                        r_wdata <= bus.mem_wdata;
                        r_be    <= bus.mem_byte_enable;
                        r_rd    <= bus.mem_read;
                        r_wr    <= bus.mem_write;
                        r_cnt   <= LAT_M1;
                        r_state <= (LATENCY > 1) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Always return to IDLE: guarantees one idle cycle between responses.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Read data is registered on the edge entering RESP and then held
            // until the next read response (writes leave it untouched).
            if (w_enter_resp) begin
                r_resp <= 1'b1;
                if (w_enter_rd) begin
                    r_rdata <= w_err_now ? 32'h0 : w_rd_word;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: byte-lane write committed on the edge ending RESP
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; clearing 2**ADDR_WIDTH words
    // would need a reset tree across the whole array, and contents are
    // meant to survive a core reset.
    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign bus.mem_rdata = r_rdata;
    assign bus.mem_resp  = r_resp;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//   Two responders share clk/rst: u_dut_a (ADDR_WIDTH=12, LATENCY=3) and
//   u_dut_b (ADDR_WIDTH=12, LATENCY=1). Expected response data and latency
//   are queued when a request is driven and compared when mem_resp appears.
//   Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mem_responder;

    logic clk;
    logic rst;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        if (sel) begin
            bus_b.mem_read = rd;  bus_b.mem_write = wr;  bus_b.mem_address = addr;
            bus_b.mem_wdata = wdata;  bus_b.mem_byte_enable = be;
        end else begin
            bus_a.mem_read = rd;  bus_a.mem_write = wr;  bus_a.mem_address = addr;
            bus_a.mem_wdata = wdata;  bus_a.mem_byte_enable = be;
        end
    endtask

    function automatic logic get_resp(input bit sel);
        return sel ? bus_b.mem_resp : bus_a.mem_resp;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus_b.mem_rdata : bus_a.mem_rdata;
    endfunction

    // One complete transaction; called and returns at a falling edge with the DUT idle.
    task automatic xact(input bit sel, input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input int lat);
        exp_t e;
        int   cyc;
        bit   got;
        sb.push_back('{tag, exp_rdata, lat});
        drive(sel, rd, wr, addr, wdata, be);
        @(posedge clk);                       // capture edge
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (get_resp(sel)) got = 1'b1;
        end
        e = sb.pop_front();
        check({e.tag, "_resp_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
            check({e.tag, "_rdata"}, get_rdata(sel), e.rdata);
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check({e.tag, "_resp_one_cycle"}, 32'(get_resp(sel)), 32'd0);
    endtask

    // Watchdog: the directed sequence is short; anything this long is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   n_resp;
        int   last_cyc;
        logic prev_resp;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_a_resp",  32'(bus_a.mem_resp), 32'd0);
        check("rst_a_rdata", bus_a.mem_rdata, 32'h0);
        check("rst_b_resp",  32'(bus_b.mem_resp), 32'd0);
        check("rst_b_rdata", bus_b.mem_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: reset in the middle of a write's WAIT phase
        xact(1'b0, "t1_seed", 1'b0, 1'b1, 32'h10, 32'h01020304, 4'hF, 32'h0, 3);
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("t1_wait_no_resp", 32'(bus_a.mem_resp), 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            check("t1_in_rst_no_resp", 32'(bus_a.mem_resp), 32'd0);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t1_after_rst_no_resp", 32'(bus_a.mem_resp), 32'd0);
        end
        xact(1'b0, "t1_read_prior", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h01020304, 3);

        // Test 2: full-word write then read, latency 3 each
        xact(1'b0, "t2_write", 1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, 32'h01020304, 3);
        xact(1'b0, "t2_read",  1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11223344, 3);

        // Test 3: partial lanes, then an empty mask
        xact(1'b0, "t3_write_0101", 1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 32'h11223344, 3);
        xact(1'b0, "t3_read_0101",  1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11BB33DD, 3);
        xact(1'b0, "t3_write_0000", 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 32'h11BB33DD, 3);
        xact(1'b0, "t3_read_0000",  1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11BB33DD, 3);

        // Test 5: upper address bits and byte offset alias onto word 0
        xact(1'b0, "t5_write_4000", 1'b0, 1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, 32'h11BB33DD, 3);
        xact(1'b0, "t5_read_0000",  1'b1, 1'b0, 32'h0000, 32'h0, 4'h0, 32'hCAFEF00D, 3);
        xact(1'b0, "t5_read_0003",  1'b1, 1'b0, 32'h0003, 32'h0, 4'h0, 32'hCAFEF00D, 3);

        // Test 6: read and write together return the pre-write word
        xact(1'b0, "t6_clear",  1'b0, 1'b1, 32'h20, 32'h00000000, 4'hF, 32'hCAFEF00D, 3);
        xact(1'b0, "t6_rw",     1'b1, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, 32'h00000000, 3);
        xact(1'b0, "t6_readback", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h5A5A5A5A, 3);

        // Test 4: LATENCY=1 instance, reads held back-to-back
        xact(1'b1, "t4_seed0", 1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, 32'h0, 1);
        xact(1'b1, "t4_seed4", 1'b0, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, 32'h0, 1);
        xact(1'b1, "t4_seed8", 1'b0, 1'b1, 32'h8, 32'hC2C2C2C2, 4'hF, 32'h0, 1);

        sb.push_back('{"t4_b2b_0", 32'hA0A0A0A0, 1});
        sb.push_back('{"t4_b2b_4", 32'hB1B1B1B1, 2});
        sb.push_back('{"t4_b2b_8", 32'hC2C2C2C2, 2});
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        n_resp    = 0;
        last_cyc  = 0;
        prev_resp = 1'b0;
        for (int cyc = 1; cyc <= 30 && n_resp < 3; cyc++) begin
            @(negedge clk);
            if (bus_b.mem_resp) begin
                e = sb.pop_front();
                check({e.tag, "_not_consecutive"}, 32'(prev_resp), 32'd0);
                check({e.tag, "_spacing"}, 32'(cyc - last_cyc), 32'(e.lat));
                check({e.tag, "_rdata"}, bus_b.mem_rdata, e.rdata);
                last_cyc = cyc;
                n_resp++;
                if (n_resp == 1)      drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
                else if (n_resp == 2) drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
                else                  drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            prev_resp = bus_b.mem_resp;
        end
        check("t4_resp_count", 32'(n_resp), 32'd3);
        repeat (2) begin
            @(negedge clk);
            check("t4_quiet_after", 32'(bus_b.mem_resp), 32'd0);
        end
        check("t4_rdata_held", bus_b.mem_rdata, 32'hC2C2C2C2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_mem_responder
